// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Loads a fixed-size instruction memory over a valid/ready
//               write port and serves it to a processor once loaded.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [AW-1:0]    wr_addr,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             run,
    output logic             load_done,
    output logic             err
);

    // Memory covers the whole address space so any rd_addr reads a defined HLT.
    localparam int               NENT   = 1 << AW;
    localparam logic [AW-1:0]    c_last = AW'(DEPTH - 1);
    localparam logic [WIDTH-1:0] c_hlt  = WIDTH'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_mem [NENT];
    logic [AW-1:0]    r_wr_addr;
    logic [AW-1:0]    w_addr_inc;
    logic             r_err;
    logic             r_load_done;

    logic             w_last;
    logic             w_ends;
    logic             w_illegal;
    logic             w_we;
    logic             w_clr;
    logic             w_err_set;
    logic [WIDTH-1:0] w_wdata;

    assign w_last     = (r_wr_addr == c_last);
    assign w_addr_inc = w_last ? '0 : r_wr_addr + 1'b1;
    // Opcode bit 1 set means HLT (10) or the illegal 11, both end the session.
    assign w_ends     = wr_data[1];
    assign w_illegal  = (wr_data[1:0] == 2'b11);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        wr_ready     = 1'b0;
        w_we         = 1'b0;
        w_clr        = 1'b0;
        w_err_set    = 1'b0;
        w_wdata      = c_hlt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_clr        = 1'b1;
                end
            end
            S_LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    w_we      = 1'b1;
                    w_wdata   = w_ends ? c_hlt : wr_data;
                    w_err_set = w_illegal;
                    if (w_last) begin
                        w_state_next = S_RUN;
                    end else if (w_ends) begin
                        w_state_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_we = 1'b1;
                if (w_last) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (start) begin
                    w_state_next = S_LOAD;
                    w_clr        = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_addr   <= '0;
            r_err       <= 1'b0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= (w_state_next == S_RUN) && (r_state != S_RUN);
            if (w_clr) begin
                r_wr_addr <= '0;
                r_err     <= 1'b0;
            end else begin
                if (w_we) begin
                    r_wr_addr <= w_addr_inc;
                end
                if (w_err_set) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NENT; i++) begin
                r_mem[i] <= c_hlt;
            end
        end else if (w_we) begin
            r_mem[r_wr_addr] <= w_wdata;
        end
    end

    assign run       = (r_state == S_RUN);
    assign wr_addr   = r_wr_addr;
    assign err       = r_err;
    assign load_done = r_load_done;
    // Processor sees HLT until the program is complete.
    assign rd_data   = run ? r_mem[rd_addr] : c_hlt;

endmodule
`default_nettype wire

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters: DEPTH, default 4, number of instruction words; WIDTH, default 2, bits per instruction word.
REQ-002 Opcodes: INC = 00, JNO = 01, HLT = 10; 11 is illegal.
REQ-003 Port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port `rst`, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port `start`, input, 1 bit: request to begin a program-load session.
REQ-006 Port `wr_valid`, input, 1 bit: the writer presents a word on `wr_data`.
REQ-007 Port `wr_data`, input, WIDTH bits: instruction word to store.
REQ-008 Port `wr_ready`, output, 1 bit: the loader accepts a word this cycle.
REQ-009 Port `wr_addr`, output, log2(DEPTH) bits: current write pointer.
REQ-010 Port `rd_addr`, input, log2(DEPTH) bits: instruction address from the processor.
REQ-011 Port `rd_data`, output, WIDTH bits: instruction word returned to the processor.
REQ-012 Port `run`, output, 1 bit: level; the program is loaded and the processor may execute.
REQ-013 Port `load_done`, output, 1 bit: one-cycle pulse when loading completes.
REQ-014 Port `err`, output, 1 bit: sticky flag; an illegal opcode was written.

Function
REQ-015 The loader SHALL implement an FSM with four states: IDLE, LOAD, FILL and RUN.
REQ-016 IDLE: `wr_ready` SHALL be 0 and `run` SHALL be 0; `start`=1 SHALL move to LOAD, set `wr_addr` to 0 and clear `err`.
REQ-017 LOAD: `wr_ready` SHALL be 1; a transfer occurs only when `wr_valid` and `wr_ready` are both 1 at a rising edge.
REQ-018 On a transfer, mem[`wr_addr`] SHALL take `wr_data` and `wr_addr` SHALL increment by 1.
REQ-019 `wr_addr` SHALL wrap modulo DEPTH.
REQ-020 A transfer at `wr_addr` = DEPTH-1 SHALL move to RUN on the next cycle; a HLT written there causes no FILL.
REQ-021 A transfer of HLT at `wr_addr` < DEPTH-1 SHALL end the session: the FSM moves to FILL with `wr_addr` = the next address.
REQ-022 A transfer of 11 SHALL store HLT (10), set `err`, and then behave exactly as a HLT transfer.
REQ-023 FILL: `wr_ready` SHALL be 0; HLT SHALL be written to mem[`wr_addr`] with `wr_addr` incremented, one entry per cycle.
REQ-024 FILL SHALL move to RUN after the write to entry DEPTH-1.
REQ-025 `load_done` SHALL pulse high for exactly the first cycle in which `run`=1.
REQ-026 RUN: `run` SHALL be 1 and `wr_ready` SHALL be 0.
REQ-027 `start`=1 in RUN SHALL drop `run` next cycle, move to LOAD, zero `wr_addr` and clear `err`; this is a reload.
REQ-028 `start` SHALL be ignored in LOAD and FILL.
REQ-029 `wr_valid` SHALL be ignored outside LOAD.
REQ-030 `rd_data` SHALL be combinational: mem[`rd_addr`] when `run`=1, otherwise HLT (10), so the processor halts during loading.
REQ-031 No write SHALL ever reach the memory when `wr_ready`=0.

Reset
REQ-032 `rst`=0 SHALL asynchronously force the FSM to IDLE, `wr_addr`=0, `run`=0, `load_done`=0, `err`=0 and `wr_ready`=0.
REQ-033 `rst`=0 SHALL asynchronously set every memory entry to HLT (10).
REQ-034 Reset asserted mid-LOAD or mid-FILL SHALL abandon the session with no further writes; after release the FSM waits in IDLE.
REQ-035 Release of `rst` SHALL take effect only at a rising `clk` edge; no state changes while `rst`=0.

Verification
REQ-036 Full load: reset, pulse `start`, write 00,01,01,10 with `wr_valid` held high -> `load_done` one cycle after the 4th transfer, `run`=1, `rd_data` for addresses 0..3 = 00,01,01,10.
REQ-037 Early HLT: load 00,10 -> FILL writes entries 2,3 = 10 over 2 cycles with `wr_ready`=0 -> `run`=1, memory = 00,10,10,10.
REQ-038 Illegal opcode: load 01,11 -> `err`=1, entry 1 = 10, entries 2,3 = 10, `run`=1; a later `start` clears `err`.
REQ-039 Handshake stall: in LOAD toggle `wr_valid` 1,0,0,1,1,1 -> exactly 4 writes, `wr_addr` advances only on valid cycles; `rd_data` = 10 throughout loading.
REQ-040 Reload/reset: in RUN pulse `start` -> `run`=0 next cycle; then assert `rst` after 2 transfers -> all entries = 10, IDLE, `wr_ready`=0, `start` in LOAD/FILL has no effect.
